// File: rtl/tenyr_mailbox_if.sv
// Bus-control and stream handshake bundle for tenyr_mailbox.
// The master side is the core plus peripherals; the slave side is the mailbox.
interface tenyr_mailbox_if;
    logic        strobe;
    logic        mem_rw;
    logic [31:0] d_addr;

    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport master (
        output strobe, mem_rw, d_addr, tx_ready, rx_data, rx_valid,
        input  tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  strobe, mem_rw, d_addr, tx_ready, rx_data, rx_valid,
        output tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/tenyr_mailbox.sv
// tenyr_mailbox: memory-mapped TX/RX FIFO mailbox responding on the tenyr data bus.
// Define TENYR_MAILBOX_IRQ_EN to add the registered irq output.
module tenyr_mailbox #(
    parameter logic [31:0] BASE       = 32'h0000_0100,
    parameter int          DEPTH_LOG2 = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    tenyr_mailbox_if.slave bus,
    inout  wire  [31:0]    d_data
`ifdef TENYR_MAILBOX_IRQ_EN
    ,
    output logic           irq
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [CW-1:0]         cnt_t;

    logic [31:0] tx_mem_q [DEPTH];
    logic [31:0] tx_mem_d [DEPTH];
    logic [31:0] rx_mem_q [DEPTH];
    logic [31:0] rx_mem_d [DEPTH];

    ptr_t tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    ptr_t rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    cnt_t tx_count_q, tx_count_d, rx_count_q, rx_count_d;

    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;
    logic irq_en_q, irq_en_d;

    logic        sel, acc_load, acc_store, rd_en;
    logic [1:0]  reg_idx;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic        flush_tx, flush_rx;
    logic [31:0] status;
    logic [31:0] rd_data;

    assign sel       = bus.strobe && (bus.d_addr[31:2] == BASE[31:2]);
    assign reg_idx   = bus.d_addr[1:0];
    assign acc_load  = sel && !bus.mem_rw;
    assign acc_store = sel && bus.mem_rw;

    assign tx_full  = (tx_count_q == cnt_t'(DEPTH));
    assign tx_empty = (tx_count_q == '0);
    assign rx_full  = (rx_count_q == cnt_t'(DEPTH));
    assign rx_empty = (rx_count_q == '0);

    // Full/empty come from pre-edge state, so a push into a full FIFO is
    // refused even when a pop frees a slot on the same edge.
    assign tx_push  = acc_store && (reg_idx == 2'd0) && !tx_full;
    assign tx_pop   = !tx_empty && bus.tx_ready;
    assign rx_push  = bus.rx_valid && !rx_full;
    assign rx_pop   = acc_load && (reg_idx == 2'd0) && !rx_empty;
    assign flush_tx = acc_store && (reg_idx == 2'd2) && d_data[0];
    assign flush_rx = acc_store && (reg_idx == 2'd2) && d_data[1];

    assign bus.tx_valid = !tx_empty;
    assign bus.tx_data  = tx_mem_q[tx_rptr_q];
    assign bus.rx_ready = !rx_full;

    always_comb begin
        tx_mem_d   = tx_mem_q;
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_count_d = tx_count_q + cnt_t'(tx_push) - cnt_t'(tx_pop);

        if (tx_push) begin
            tx_mem_d[tx_wptr_q] = d_data;
            tx_wptr_d           = tx_wptr_q + ptr_t'(1);
        end
        if (tx_pop) begin
            tx_rptr_d = tx_rptr_q + ptr_t'(1);
        end
        if (flush_tx) begin
            tx_wptr_d  = '0;
            tx_rptr_d  = '0;
            tx_count_d = '0;
        end
    end

    always_comb begin
        rx_mem_d   = rx_mem_q;
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_count_d = rx_count_q + cnt_t'(rx_push) - cnt_t'(rx_pop);

        if (rx_push) begin
            rx_mem_d[rx_wptr_q] = bus.rx_data;
            rx_wptr_d           = rx_wptr_q + ptr_t'(1);
        end
        if (rx_pop) begin
            rx_rptr_d = rx_rptr_q + ptr_t'(1);
        end
        if (flush_rx) begin
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_count_d = '0;
        end
    end

    // A STATUS load clears the sticky flags, but a new error on the same edge wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        irq_en_d    = irq_en_q;

        if (acc_load && (reg_idx == 2'd1)) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (acc_store && (reg_idx == 2'd0) && tx_full) begin
            overflow_d = 1'b1;
        end
        if (acc_load && (reg_idx == 2'd0) && rx_empty) begin
            underflow_d = 1'b1;
        end
        if (acc_store && (reg_idx == 2'd2)) begin
            irq_en_d = d_data[2];
        end
    end

    always_comb begin
        status        = 32'b0;
        status[7:0]   = 8'(rx_count_q);
        status[15:8]  = 8'(tx_count_q);
        status[16]    = !rx_empty;
        status[17]    = tx_full;
        status[18]    = overflow_q;
        status[19]    = underflow_q;
    end

    always_comb begin
        rd_data = 32'b0;
        case (reg_idx)
            2'd0:    rd_data = rx_empty ? 32'b0 : rx_mem_q[rx_rptr_q];
            2'd1:    rd_data = status;
            2'd2:    rd_data = {29'b0, irq_en_q, 2'b0};
            default: rd_data = 32'b0;
        endcase
    end

    // Shared with RAM: drive only for an addressed load, and never while in reset.
    assign rd_en  = acc_load && reset_n;
    assign d_data = rd_en ? rd_data : 32'bz;

    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_count_q  <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_count_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            irq_en_q    <= 1'b0;
        end else begin
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            tx_count_q  <= tx_count_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_count_q  <= rx_count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            irq_en_q    <= irq_en_d;
        end
    end

`ifdef TENYR_MAILBOX_IRQ_EN
    logic irq_q, irq_d;

    // Built from next-state values so irq tracks the state the edge produces.
    assign irq_d = irq_en_d && ((rx_count_d != '0) || overflow_d || underflow_d);
    assign irq   = irq_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
`endif
endmodule

// File: tb/tb_tenyr_mailbox.sv
// Directed self-checking bench for tenyr_mailbox (default build, DEPTH_LOG2=3, BASE=0x100).
module tb_tenyr_mailbox;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    tenyr_mailbox_if bus();

    wire  [31:0] d_data;
    logic        tb_drv;
    logic [31:0] tb_wdata;
    assign d_data = tb_drv ? tb_wdata : 32'bz;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rdata;

`ifdef TENYR_MAILBOX_IRQ_EN
    wire irq_w;
`endif

    tenyr_mailbox dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .d_data  (d_data)
`ifdef TENYR_MAILBOX_IRQ_EN
        ,
        .irq     (irq_w)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One strobe cycle: drive at negedge, capture load data mid-cycle, release after the edge.
    task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rd);
        @(negedge clk);
        bus.strobe = 1'b1;
        bus.mem_rw = rw;
        bus.d_addr = addr;
        tb_drv     = rw;
        tb_wdata   = wdata;
        #1 rd = d_data;
        @(posedge clk);
        #1;
        bus.strobe = 1'b0;
        bus.mem_rw = 1'b0;
        bus.d_addr = 32'h0;
        tb_drv     = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.strobe   = 1'b0;
        bus.mem_rw   = 1'b0;
        bus.d_addr   = 32'h0;
        bus.tx_ready = 1'b0;
        bus.rx_data  = 32'h0;
        bus.rx_valid = 1'b0;
        tb_drv       = 1'b0;
        tb_wdata     = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        checkOutput("reset_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
        checkOutput("reset_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("reset_status", rdata, 32'h0);

        applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, rdata);
        applyStimulus(1'b1, 32'h100, 32'h12345678, rdata);
        checkOutput("tx_valid_after_push", {31'b0, bus.tx_valid}, 32'h1);
        checkOutput("tx_head0", bus.tx_data, 32'hDEADBEEF);
        bus.tx_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("tx_head1", bus.tx_data, 32'h12345678);
        @(posedge clk); #1;
        checkOutput("tx_drained", {31'b0, bus.tx_valid}, 32'h0);
        bus.tx_ready = 1'b0;

        applyStimulus(1'b0, 32'h100, 32'h0, rdata);
        checkOutput("rx_empty_load", rdata, 32'h0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 32'h100, 32'hC000_0000 + i, rdata);
        end
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("status_tx_full_flags", rdata, 32'h000E_0800);
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("status_flags_cleared", rdata, 32'h0002_0800);
        checkOutput("tx_full_head", bus.tx_data, 32'hC000_0000);

        bus.tx_ready = 1'b1;
        applyStimulus(1'b1, 32'h100, 32'h0000_00EE, rdata);
        bus.tx_ready = 1'b0;
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("status_full_push_pop", rdata, 32'h0004_0700);
        checkOutput("tx_head_after_pop", bus.tx_data, 32'hC000_0001);

        applyStimulus(1'b1, 32'h102, 32'h5, rdata);
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("status_after_tx_flush", rdata, 32'h0);
        applyStimulus(1'b0, 32'h102, 32'h0, rdata);
        checkOutput("control_irq_en", rdata, 32'h4);
        checkOutput("tx_valid_after_flush", {31'b0, bus.tx_valid}, 32'h0);

        bus.rx_valid = 1'b1;
        bus.rx_data  = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        applyStimulus(1'b0, 32'h100, 32'h0, rdata);
        checkOutput("rx_load_word", rdata, 32'hA5A5A5A5);
        applyStimulus(1'b0, 32'h100, 32'h0, rdata);
        checkOutput("rx_load_empty", rdata, 32'h0);
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("status_underflow", rdata, 32'h0008_0000);

        bus.rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.rx_data = 32'h1000_0000 + i;
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
        checkOutput("rx_ready_full", {31'b0, bus.rx_ready}, 32'h0);
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("status_rx_full", rdata, 32'h0001_0008);

        bus.rx_valid = 1'b1;
        bus.rx_data  = 32'hBAD0BAD0;
        checkOutput("rx_ready_full_pop", {31'b0, bus.rx_ready}, 32'h0);
        applyStimulus(1'b0, 32'h100, 32'h0, rdata);
        bus.rx_valid = 1'b0;
        checkOutput("rx_full_pop_word", rdata, 32'h1000_0000);
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("status_rx_count7", rdata, 32'h0001_0007);

        bus.rx_valid = 1'b1;
        bus.rx_data  = 32'h2000_0000;
        applyStimulus(1'b0, 32'h100, 32'h0, rdata);
        bus.rx_valid = 1'b0;
        checkOutput("rx_push_pop_word", rdata, 32'h1000_0001);
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("status_push_pop", rdata, 32'h0001_0007);
        for (int i = 2; i < 8; i++) begin
            applyStimulus(1'b0, 32'h100, 32'h0, rdata);
            checkOutput("rx_drain", rdata, 32'h1000_0000 + i);
        end
        applyStimulus(1'b0, 32'h100, 32'h0, rdata);
        checkOutput("rx_drain_last", rdata, 32'h2000_0000);

        bus.rx_valid = 1'b1;
        bus.rx_data  = 32'h0000_0077;
        applyStimulus(1'b0, 32'h100, 32'h0, rdata);
        bus.rx_valid = 1'b0;
        checkOutput("rx_empty_push_load", rdata, 32'h0);
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("status_empty_push", rdata, 32'h0009_0001);
        applyStimulus(1'b0, 32'h100, 32'h0, rdata);
        checkOutput("rx_pushed_word", rdata, 32'h0000_0077);

        bus.rx_valid = 1'b1;
        bus.rx_data  = 32'h0000_0088;
        @(posedge clk); #1;
        bus.rx_data  = 32'h0000_0099;
        applyStimulus(1'b1, 32'h102, 32'h6, rdata);
        bus.rx_valid = 1'b0;
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("status_rx_flush", rdata, 32'h0);

        applyStimulus(1'b1, 32'h103, 32'hFFFF_FFFF, rdata);
        applyStimulus(1'b1, 32'h101, 32'hFFFF_FFFF, rdata);
        applyStimulus(1'b1, 32'h200, 32'h0000_1234, rdata);
        applyStimulus(1'b0, 32'h103, 32'h0, rdata);
        checkOutput("reg3_load", rdata, 32'h0);
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("status_ignored_stores", rdata, 32'h0);
        applyStimulus(1'b0, 32'h102, 32'h0, rdata);
        checkOutput("control_kept", rdata, 32'h4);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h100, 32'hD000_0000 + i, rdata);
        end
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.rx_data = 32'hE000_0000 + i;
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("status_half_full", rdata, 32'h0001_0404);

        reset_n = 1'b0;
        applyStimulus(1'b1, 32'h102, 32'h3, rdata);
        reset_n = 1'b1;
        checkOutput("mid_reset_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
        checkOutput("mid_reset_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
        applyStimulus(1'b0, 32'h101, 32'h0, rdata);
        checkOutput("mid_reset_status", rdata, 32'h0);
        applyStimulus(1'b0, 32'h102, 32'h0, rdata);
        checkOutput("mid_reset_control", rdata, 32'h0);
        applyStimulus(1'b1, 32'h100, 32'h0000_0055, rdata);
        checkOutput("post_reset_push", bus.tx_data, 32'h0000_0055);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
